if_stage_ctrl: RTL and testbench

Instruction-fetch stage controller for the 5-stage pipelined MIPS core. It sits on the consuming end of the load-use hazard unit's PCWrite/IFIDWrite outputs. It owns the PC register, the fetch handshake to a variable-latency instruction memory, and the IF/ID pipeline register. It honours stalls without losing a returned instruction, and applies branch redirects/flushes from ID.

---
 rtl/if_stage_ctrl.sv | 166 ++++++++++++++++
 tb/tb_if_stage_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: owns the PC, the fetch handshake to a
// variable-latency instruction memory and the IF/ID pipeline register.
// Stalls from the hazard unit never lose a returned word (it parks in a hold
// buffer), and branch redirects from ID flush IF/ID and steer the next fetch.
module if_stage_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              IFIDWrite,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemReady,
  input  logic [31:0]       ImemRdata,
  output logic [31:0]       IFIDInstr,
  output logic [ADDR_W-1:0] IFIDPCPlus4,
  output logic              IFIDValid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       instr_q, instr_n;
  logic [ADDR_W-1:0] pcp4_q, pcp4_n;
  logic              valid_q, valid_n;
  logic [31:0]       hold_instr, hold_instr_n;
  logic [ADDR_W-1:0] hold_pcp4, hold_pcp4_n;

  logic              accept;
  logic [ADDR_W-1:0] pc_plus4;

  assign accept   = PCWrite & IFIDWrite;
  assign pc_plus4 = pc + ADDR_W'(4);

  assign ImemReq     = (state == S_REQ) || (state == S_DRAIN);
  assign ImemAddr    = addr_q;
  assign IFIDInstr   = instr_q;
  assign IFIDPCPlus4 = pcp4_q;
  assign IFIDValid   = valid_q;

  // State, PC, fetch address, IF/ID and hold buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pcp4_q     <= '0;
      valid_q    <= 1'b0;
      hold_instr <= '0;
      hold_pcp4  <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      addr_q     <= addr_n;
      instr_q    <= instr_n;
      pcp4_q     <= pcp4_n;
      valid_q    <= valid_n;
      hold_instr <= hold_instr_n;
      hold_pcp4  <= hold_pcp4_n;
    end
  end

  // Next-state and datapath decisions; redirect outranks data return and stalls
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    addr_n       = addr_q;
    instr_n      = instr_q;
    pcp4_n       = pcp4_q;
    valid_n      = valid_q;
    hold_instr_n = hold_instr;
    hold_pcp4_n  = hold_pcp4;

    case (state)
      S_IDLE: begin
        addr_n  = pc;
        state_n = S_REQ;
      end

      S_REQ: begin
        if (BranchTaken) begin
          pc_n    = BranchTarget;
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
          if (ImemReady) begin
            addr_n  = BranchTarget;
            state_n = S_REQ;
          end else begin
            // The outstanding fetch cannot be withdrawn: keep asking at the
            // old address and discard whatever comes back.
            state_n = S_DRAIN;
          end
        end else if (ImemReady) begin
          if (accept) begin
            instr_n = ImemRdata;
            pcp4_n  = pc_plus4;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
            addr_n  = pc_plus4;
          end else begin
            hold_instr_n = ImemRdata;
            hold_pcp4_n  = pc_plus4;
            state_n      = S_HOLD;
            // The word is parked, not delivered, so a writable IF/ID sees a bubble.
            if (IFIDWrite) begin
              instr_n = NOP_INSTR;
              valid_n = 1'b0;
            end
          end
        end else if (IFIDWrite) begin
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
        end
      end

      S_HOLD: begin
        if (BranchTaken) begin
          pc_n    = BranchTarget;
          addr_n  = BranchTarget;
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
          state_n = S_REQ;
        end else if (accept) begin
          instr_n = hold_instr;
          pcp4_n  = hold_pcp4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
          addr_n  = pc_plus4;
          state_n = S_REQ;
        end
      end

      S_DRAIN: begin
        if (BranchTaken) begin
          pc_n    = BranchTarget;
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
        end
        // A redirect landing in the same cycle as the drained return must
        // take effect, so the new fetch uses the already-updated PC.
        if (ImemReady) begin
          addr_n  = pc_n;
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Randomized bench for if_stage_ctrl: a variable-latency memory model answers
// fetches, the hazard/branch inputs are randomized, and a transaction-level
// reference model predicts every output each cycle.
module tb_if_stage_ctrl;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0020;

  logic              clk;
  logic              rst_n;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic              ImemReady;
  logic [31:0]       ImemRdata;
  logic [31:0]       IFIDInstr;
  logic [ADDR_W-1:0] IFIDPCPlus4;
  logic              IFIDValid;

  if_stage_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemReady   (ImemReady),
    .ImemRdata   (ImemRdata),
    .IFIDInstr   (IFIDInstr),
    .IFIDPCPlus4 (IFIDPCPlus4),
    .IFIDValid   (IFIDValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Contents of instruction memory: a distinct word per address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Reference model: where fetch stands, what is parked, what IF/ID holds
  logic [31:0] m_pc, m_addr, m_instr, m_pcp4, m_hword, m_hpcp4;
  logic        m_valid, m_started, m_held, m_drain;

  // Memory model
  bit mem_pending;
  int mem_wait;

  task automatic model_reset();
    m_pc = RST_PC; m_addr = RST_PC;
    m_instr = NOP; m_pcp4 = '0; m_valid = 1'b0;
    m_started = 1'b0; m_held = 1'b0; m_drain = 1'b0;
    m_hword = '0; m_hpcp4 = '0;
    mem_pending = 1'b0; mem_wait = 0;
  endtask

  task automatic bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  // One clock edge worth of fetch-stage rules, applied to the driven inputs
  task automatic model_step();
    logic acc;
    acc = PCWrite & IFIDWrite;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (BranchTaken) begin
        m_pc = BranchTarget; m_addr = BranchTarget; m_held = 1'b0; bubble();
      end else if (acc) begin
        m_instr = m_hword; m_pcp4 = m_hpcp4; m_valid = 1'b1;
        m_pc = m_pc + 4; m_addr = m_pc; m_held = 1'b0;
      end
    end else if (m_drain) begin
      if (BranchTaken) begin
        m_pc = BranchTarget; bubble();
      end
      if (ImemReady) begin
        m_addr = m_pc; m_drain = 1'b0;
      end
    end else begin
      if (BranchTaken) begin
        m_pc = BranchTarget; bubble();
        if (ImemReady) m_addr = BranchTarget;
        else m_drain = 1'b1;
      end else if (ImemReady) begin
        if (acc) begin
          m_instr = ImemRdata; m_pcp4 = m_pc + 4; m_valid = 1'b1;
          m_pc = m_pc + 4; m_addr = m_pc;
        end else begin
          m_held = 1'b1; m_hword = ImemRdata; m_hpcp4 = m_pc + 4;
          if (IFIDWrite) bubble();
        end
      end else if (IFIDWrite) begin
        bubble();
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".req"},   ImemReq,     m_started && !m_held);
    check_eq({where, ".addr"},  ImemAddr,    m_addr);
    check_eq({where, ".instr"}, IFIDInstr,   m_instr);
    check_eq({where, ".pcp4"},  IFIDPCPlus4, m_pcp4);
    check_eq({where, ".valid"}, IFIDValid,   m_valid);
  endtask

  // One cycle, entered and left at a falling edge
  task automatic cycle(input int min_wait, input int max_wait, input int stall_pct,
                       input int br_pct, input logic [31:0] br_base, input int br_span);
    logic rdy;
    check_outputs("cyc");
    if (!ImemReq) begin
      mem_pending = 1'b0;
    end else if (!mem_pending) begin
      mem_pending = 1'b1;
      mem_wait = $urandom_range(max_wait, min_wait);
    end
    rdy = mem_pending && (mem_wait == 0);
    if (mem_pending) begin
      if (rdy) mem_pending = 1'b0;
      else mem_wait--;
    end
    ImemReady = rdy;
    ImemRdata = rdy ? word_at(ImemAddr) : $urandom;
    if ($urandom_range(99, 0) < stall_pct) begin
      case ($urandom_range(3, 0))
        0:       begin PCWrite = 1'b0; IFIDWrite = 1'b1; end
        1:       begin PCWrite = 1'b1; IFIDWrite = 1'b0; end
        default: begin PCWrite = 1'b0; IFIDWrite = 1'b0; end
      endcase
    end else begin
      PCWrite = 1'b1; IFIDWrite = 1'b1;
    end
    BranchTaken  = ($urandom_range(99, 0) < br_pct);
    BranchTarget = br_base + ($urandom_range(br_span, 0) << 2);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    PCWrite = 1'b1; IFIDWrite = 1'b1; BranchTaken = 1'b0;
    BranchTarget = '0; ImemReady = 1'b0; ImemRdata = '0;
  endtask

  // Reset asserted between edges: outputs must return to reset values at once
  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    quiet_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming from reset
    repeat (12) cycle(0, 0, 0, 0, 32'h0, 0);
    // Load-use style stalls with a zero-wait memory
    repeat (40) cycle(0, 0, 35, 0, 32'h0, 0);
    // Fixed three wait states, no stalls
    repeat (24) cycle(3, 3, 0, 0, 32'h0, 0);
    // Redirects mixed with waits and stalls
    repeat (80) cycle(0, 3, 25, 12, 32'h0000_0100, 63);
    // Address wrap at the top of memory
    cycle(0, 0, 0, 100, 32'hFFFF_FFF4, 0);
    repeat (8) cycle(0, 0, 0, 0, 32'h0, 0);
    // Reset while a fetch is outstanding
    reset_mid_cycle();
    repeat (6) cycle(2, 2, 0, 0, 32'h0, 0);
    reset_mid_cycle();
    // Long random soak
    repeat (2000) cycle(0, 4, 30, 8, 32'h0000_1000, 255);
    reset_mid_cycle();
    repeat (300) cycle(0, 2, 20, 15, 32'hFFFF_FF00, 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
